// File: rtl/uart_rx_wb.sv
// 8N1 UART receiver with a two-register Wishbone slave (data at 0x0, status at 0x4).
// Each received byte goes to the serial loader as an irq/byte pair and to the bus.
module uart_rx_wb #(
   parameter int SYS_CLK_FREQ = 100000000,
   parameter int BAUD         = 115200
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        rx_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic        wb_stall_o,
   output logic        wb_err_o,
   output logic        wb_ack_o,
   output logic [31:0] wb_dat_o,
   output logic        uart_rx_irq,
   output logic [7:0]  uart_rx_byte,
   output logic        frame_err_o
);
   localparam int N  = SYS_CLK_FREQ / BAUD;
   localparam int H  = N / 2;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] N_LAST = CW'(N - 1);
   localparam logic [CW-1:0] H_LAST = CW'(H - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          rx_meta;
   logic          rx_s;
   logic          valid;
   logic          overrun;
   logic          stb_q;
   logic          adr_q;
   logic          rd_clr;
   logic          ovr_clr;
   logic          unused_ok;

   assign unused_ok = ^{wb_sel_i, wb_adr_i[31:3], wb_adr_i[1:0], wb_dat_i[31:2], wb_dat_i[0]};

   // Sync flops reset to the idle level so reset release never looks like a start bit.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
      end
   end

   assign rd_clr  = wb_stb_i & wb_cyc_i & ~wb_we_i & ~wb_adr_i[2];
   assign ovr_clr = wb_stb_i & wb_cyc_i & wb_we_i & wb_adr_i[2] & wb_dat_i[1];

   // Bus clears come first so a same-cycle set from the receiver overrides them.
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state        <= IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         shreg        <= '0;
         uart_rx_byte <= '0;
         uart_rx_irq  <= 1'b0;
         frame_err_o  <= 1'b0;
         valid        <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         uart_rx_irq <= 1'b0;
         frame_err_o <= 1'b0;
         if (rd_clr)
            valid <= 1'b0;
         if (ovr_clr)
            overrun <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rx_s)
                  state <= START;
            end
            START: begin
               if (cnt == H_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == N_LAST) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7)
                     state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == N_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  if (rx_s) begin
                     uart_rx_byte <= shreg;
                     uart_rx_irq  <= 1'b1;
                     valid        <= 1'b1;
                     if (valid)
                        overrun <= 1'b1;
                  end else begin
                     frame_err_o <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         stb_q <= 1'b0;
         adr_q <= 1'b0;
      end else begin
         stb_q <= wb_stb_i;
         adr_q <= wb_adr_i[2];
      end
   end

   assign wb_ack_o   = stb_q & wb_cyc_i;
   assign wb_dat_o   = adr_q ? {30'b0, overrun, valid} : {24'b0, uart_rx_byte};
   assign wb_stall_o = 1'b0;
   assign wb_err_o   = 1'b0;
endmodule
